// File: rtl/simple_pkg.sv
// Shared constants and types for the ALU writeback stage.
// Condition codes, flag bit positions and the held result entry.
package simple_pkg;

    localparam logic [2:0] BR_AL  = 3'b000;
    localparam logic [2:0] BR_BE  = 3'b001;
    localparam logic [2:0] BR_BLT = 3'b010;
    localparam logic [2:0] BR_BLE = 3'b011;
    localparam logic [2:0] BR_BNE = 3'b100;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        en;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Beat bus between ALU and writeback: input beat channel plus
// result channel. master = producer/consumer side, slave = stage.
interface alu_writeback_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_res;
    logic [3:0]  alu_szcv;
    logic [2:0]  rd;
    logic        wr_en;
    logic        set_flags;
    logic        br_en;
    logic [2:0]  br_cond;
    logic [15:0] br_target;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_en;

    modport master (
        output in_valid, alu_res, alu_szcv, rd, wr_en,
        output set_flags, br_en, br_cond, br_target,
        input  in_ready,
        input  out_valid, wb_data, wb_rd, wb_en,
        output out_ready
    );

    modport slave (
        input  in_valid, alu_res, alu_szcv, rd, wr_en,
        input  set_flags, br_en, br_cond, br_target,
        output in_ready,
        output out_valid, wb_data, wb_rd, wb_en,
        input  out_ready
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition decode.
// Ports: flags {S,Z,C,V}, br_cond code in; take out.
module branch_cond
    import simple_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] br_cond,
    output logic       take
);

    logic s, z, v;

    assign s = flags[FLAG_S];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (br_cond)
            BR_AL:   take = 1'b1;
            BR_BE:   take = z;
            BR_BLT:  take = s ^ v;
            BR_BLE:  take = z | (s ^ v);
            BR_BNE:  take = ~z;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry result buffer, flag register, branch
// resolution. Ports: clk, rst, bus (slave), flush, flags, br_taken, br_pc.
module alu_writeback
    import simple_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_writeback_if.slave bus,
    input  logic        flush,
    output logic [3:0]  flags,
    output logic        br_taken,
    output logic [15:0] br_pc
);

    wb_entry_t   ent_q;
    logic        out_valid_q;
    logic        shadow_q;
    logic [3:0]  flags_q;
    logic        taken_q;
    logic [15:0] pc_q;
    logic        ready;
    logic        accept;
    logic        take;
    logic        br_hit;

    // The beat right after a taken branch is on the wrong path.
    assign ready  = (~out_valid_q | bus.out_ready) & ~shadow_q;
    assign accept = bus.in_valid & ready & ~flush;

    // Condition is checked against flags from before this beat.
    branch_cond u_cond (
        .flags   (flags_q),
        .br_cond (bus.br_cond),
        .take    (take)
    );

    assign br_hit = accept & bus.br_en & take;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q       <= '0;
            out_valid_q <= 1'b0;
            shadow_q    <= 1'b0;
            flags_q     <= 4'b0000;
            taken_q     <= 1'b0;
            pc_q        <= 16'h0000;
        end else begin
            shadow_q <= br_hit;
            taken_q  <= br_hit;
            pc_q     <= br_hit ? bus.br_target : 16'h0000;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                ent_q.data  <= bus.alu_res;
                ent_q.rd    <= bus.rd;
                ent_q.en    <= bus.wr_en;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && bus.set_flags) begin
                flags_q <= bus.alu_szcv;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.wb_data   = ent_q.data;
    assign bus.wb_rd     = ent_q.rd;
    assign bus.wb_en     = out_valid_q & ent_q.en;

    assign flags    = flags_q;
    assign br_taken = taken_q;
    assign br_pc    = pc_q;

endmodule
